// File: rtl/rv32e_spi_pkg.sv
// rtl/rv32e_spi_pkg.sv - shared types and constants for the SPI memory arbiter
package rv32e_spi_pkg;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_e;
  typedef enum logic {REQ_FETCH, REQ_DATA} req_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;

  function automatic logic [5:0] size_bits(input logic [1:0] size);
    case (size)
      SZ_B:    return 6'd8;
      SZ_H:    return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - two-phase SPI bit clock with a 32-bit shift register
module spi_shift_engine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        start,
  input  logic [31:0] tx_word,
  input  logic [5:0]  nbits,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        bit_done,
  output logic        phase_done,
  output logic [31:0] rx_word
);

  logic [31:0] sh;
  logic [4:0]  cnt;
  logic [4:0]  last;
  logic        hi;
  logic        run;

  assign sclk       = run & hi;
  assign mosi       = run & sh[31];
  assign bit_done   = run & hi;
  assign phase_done = run && (cnt == last);
  // Includes the bit being sampled on this edge so the caller can grab it directly.
  assign rx_word    = {sh[30:0], miso};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      cnt  <= '0;
      last <= '0;
      hi   <= 1'b0;
      run  <= 1'b0;
    end else begin
      if (load)
        sh <= tx_word;
      else if (bit_done)
        sh <= {sh[30:0], miso};

      if (start) begin
        cnt  <= '0;
        last <= 5'(nbits - 6'd1);
        hi   <= 1'b0;
        run  <= 1'b1;
      end else if (run) begin
        hi <= ~hi;
        if (hi) begin
          if (cnt == last) begin
            cnt <= '0;
            run <= 1'b0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// rtl/spi_mem_arbiter.sv - round-robin fetch/data arbiter sequencing SPI flash and RAM transactions
module spi_mem_arbiter
  import rv32e_spi_pkg::*;
#(
  parameter int         ADDR_W    = 25,
  parameter logic [7:0] CMD_READ  = OP_READ,
  parameter logic [7:0] CMD_WRITE = OP_WRITE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_done,
  output logic [31:0]       fetch_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_done,
  output logic [31:0]       data_rdata,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_cs1_n,
  output logic              spi_cs2_n,
  output logic              busy
);

  state_e            state, state_n;
  req_e              last_grant, gnt, pick, done_gnt;
  logic [23:0]       addr_q;
  logic              we_q;
  logic [5:0]        dbits_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we, sel_ram, accept;
  logic [5:0]        sel_bits;
  logic              eng_load, bit_done, phase_done, phase_end;
  logic [31:0]       eng_tx, rx_word, rd_word, done_rdata;
  logic [5:0]        eng_nbits;

  spi_shift_engine u_engine (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (eng_load),
    .start      (eng_load),
    .tx_word    (eng_tx),
    .nbits      (eng_nbits),
    .miso       (spi_miso),
    .sclk       (spi_sclk),
    .mosi       (spi_mosi),
    .bit_done   (bit_done),
    .phase_done (phase_done),
    .rx_word    (rx_word)
  );

  assign phase_end = bit_done & phase_done;
  assign busy      = (state != IDLE);

  always_comb begin
    pick = REQ_DATA;
    if (fetch_req && data_req)
      pick = (last_grant == REQ_FETCH) ? REQ_DATA : REQ_FETCH;
    else if (fetch_req)
      pick = REQ_FETCH;
  end

  assign sel_addr = (pick == REQ_FETCH) ? fetch_addr : data_addr;
  assign sel_we   = (pick == REQ_DATA) && data_we;
  assign sel_ram  = sel_addr[ADDR_W-1];
  assign sel_bits = (pick == REQ_FETCH) ? 6'd32 : size_bits(data_size);
  assign done_gnt = accept ? pick : gnt;

  // Received bytes arrive byte0-first in the low 8N bits; left-align then swap to little-endian.
  assign rd_word    = swap_bytes(rx_word << (6'd32 - dbits_q));
  assign done_rdata = (state == DATA && !we_q) ? rd_word : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    eng_load  = 1'b0;
    eng_tx    = '0;
    eng_nbits = '0;
    case (state)
      IDLE: if (fetch_req || data_req) begin
        accept = 1'b1;
        if (sel_we && !sel_ram) begin
          state_n = DONE;
        end else begin
          state_n   = CMD;
          eng_load  = 1'b1;
          eng_tx    = {sel_we ? CMD_WRITE : CMD_READ, 24'h0};
          eng_nbits = 6'd8;
        end
      end
      CMD: if (phase_end) begin
        state_n   = ADDR;
        eng_load  = 1'b1;
        eng_tx    = {addr_q, 8'h00};
        eng_nbits = 6'd24;
      end
      ADDR: if (phase_end) begin
        state_n   = DATA;
        eng_load  = 1'b1;
        eng_tx    = we_q ? swap_bytes(wdata_q) : 32'h0;
        eng_nbits = dbits_q;
      end
      DATA:    if (phase_end) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant  <= REQ_DATA;
      gnt         <= REQ_DATA;
      addr_q      <= '0;
      we_q        <= 1'b0;
      dbits_q     <= '0;
      wdata_q     <= '0;
      spi_cs1_n   <= 1'b1;
      spi_cs2_n   <= 1'b1;
      fetch_done  <= 1'b0;
      data_done   <= 1'b0;
      fetch_rdata <= '0;
      data_rdata  <= '0;
    end else begin
      fetch_done <= 1'b0;
      data_done  <= 1'b0;
      if (accept) begin
        last_grant <= pick;
        gnt        <= pick;
        addr_q     <= sel_addr[23:0];
        we_q       <= sel_we;
        dbits_q    <= sel_bits;
        wdata_q    <= data_wdata;
        if (state_n == CMD) begin
          spi_cs1_n <= sel_ram;
          spi_cs2_n <= !sel_ram;
        end
      end
      if (state == DATA && phase_end) begin
        spi_cs1_n <= 1'b1;
        spi_cs2_n <= 1'b1;
      end
      if (state_n == DONE && state != DONE) begin
        if (done_gnt == REQ_FETCH) begin
          fetch_done  <= 1'b1;
          fetch_rdata <= done_rdata;
        end else begin
          data_done  <= 1'b1;
          data_rdata <= done_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb/tb_spi_mem_arbiter.sv - scoreboard bench with SPI slave model for spi_mem_arbiter
module tb_spi_mem_arbiter;

  typedef struct {
    bit          is_fetch;
    bit          we;
    logic [1:0]  size;
    logic [24:0] addr;
    logic [31:0] wdata;
    logic [31:0] miso;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  typedef struct {
    bit          is_fetch;
    bit          wr;
    logic [31:0] miso;
    logic [31:0] rdata;
    logic [31:0] hdr;
    logic [31:0] dat;
    int          nbits;
    logic [1:0]  cs;
    int          lat;
    int          start;
  } sb_t;

  logic        clk, rst_n;
  logic        fetch_req, fetch_done;
  logic [24:0] fetch_addr;
  logic [31:0] fetch_rdata;
  logic        data_req, data_we, data_done;
  logic [1:0]  data_size;
  logic [24:0] data_addr;
  logic [31:0] data_wdata, data_rdata;
  logic        spi_sclk, spi_mosi, spi_miso, spi_cs1_n, spi_cs2_n, busy;

  int          n_cmp, n_fail, cyc, cap_n;
  logic [31:0] cap_hdr, cap_dat;
  logic [1:0]  cs_seen;
  sb_t         sb[$];
  vec_t        tbl[8];

  spi_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_done(fetch_done), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_done(data_done), .data_rdata(data_rdata),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_cs1_n(spi_cs1_n), .spi_cs2_n(spi_cs2_n), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: actual=no completion required=completion (cycle %0d)", name, cyc);
    sb.delete();
    fetch_req = 1'b0;
    data_req  = 1'b0;
  endtask

  function automatic vec_t mkv(input bit f, input bit we, input logic [1:0] sz, input logic [24:0] a,
                               input logic [31:0] wd, input logic [31:0] mi, input logic [31:0] rd, input int lat);
    vec_t v;
    v.is_fetch = f; v.we = we; v.size = sz; v.addr = a;
    v.wdata = wd; v.miso = mi; v.rdata = rd; v.lat = lat;
    return v;
  endfunction

  function automatic sb_t mk(input vec_t v, input int lat, input int start);
    sb_t e;
    int  n;
    e.is_fetch = v.is_fetch;
    e.wr       = !v.is_fetch && v.we;
    e.miso     = v.miso;
    e.rdata    = v.rdata;
    e.lat      = lat;
    e.start    = start;
    n = v.is_fetch ? 4 : (v.size == 2'd0 ? 1 : (v.size == 2'd1 ? 2 : 4));
    e.hdr = {e.wr ? 8'h02 : 8'h03, v.addr[23:0]};
    e.dat = 32'h0;
    if (e.wr)
      for (int k = 0; k < n; k++) e.dat = (e.dat << 8) | 32'(v.wdata[8*k +: 8]);
    if (e.wr && !v.addr[24]) begin
      e.nbits = 0;
      e.cs    = 2'b00;
    end else begin
      e.nbits = 32 + 8 * n;
      e.cs    = v.addr[24] ? 2'b10 : 2'b01;
    end
    return e;
  endfunction

  // One cycle: check completions against the scoreboard, then run the SPI slave model.
  task automatic tick();
    sb_t         e;
    int          idx;
    logic [31:0] w;
    @(negedge clk);
    cyc++;
    if (fetch_done || data_done) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 64'({fetch_done, data_done}), 64'h0);
      end else begin
        e = sb.pop_front();
        chk("done_port", 64'({fetch_done, data_done}), e.is_fetch ? 64'h2 : 64'h1);
        if (!e.wr) chk("rdata", 64'(e.is_fetch ? fetch_rdata : data_rdata), 64'(e.rdata));
        chk("sclk_bits", 64'(cap_n), 64'(e.nbits));
        if (e.nbits != 0) chk("mosi_hdr", 64'(cap_hdr), 64'(e.hdr));
        if (e.wr && e.nbits != 0) chk("mosi_data", 64'(cap_dat), 64'(e.dat));
        chk("cs_used", 64'(cs_seen), 64'(e.cs));
        if (e.lat != 0) chk("latency", 64'(cyc - e.start), 64'(e.lat));
      end
    end
    if (!spi_cs1_n || !spi_cs2_n) begin
      cs_seen = cs_seen | {~spi_cs2_n, ~spi_cs1_n};
      if (spi_sclk) begin
        if (cap_n < 32) cap_hdr = {cap_hdr[30:0], spi_mosi};
        else            cap_dat = {cap_dat[30:0], spi_mosi};
        cap_n++;
      end else begin
        idx = cap_n - 32;
        w   = (sb.size() != 0) ? sb[0].miso : 32'h0;
        spi_miso = (idx >= 0 && idx < 32) ? w[(idx / 8) * 8 + 7 - (idx % 8)] : 1'b0;
      end
    end else begin
      if (spi_sclk) chk("sclk_without_cs", 64'(spi_sclk), 64'h0);
      cap_n = 0; cap_hdr = '0; cap_dat = '0; cs_seen = '0; spi_miso = 1'b0;
    end
  endtask

  task automatic drive(input vec_t v);
    if (v.is_fetch) begin
      fetch_addr = v.addr;
      fetch_req  = 1'b1;
    end else begin
      data_addr  = v.addr;
      data_we    = v.we;
      data_size  = v.size;
      data_wdata = v.wdata;
      data_req   = 1'b1;
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    tick();
    chk("idle_before_req", 64'(busy), 64'h0);
    sb.push_back(mk(v, v.lat, cyc));
    drive(v);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if ((v.is_fetch && fetch_done) || (!v.is_fetch && data_done)) begin
        fetch_req = 1'b0;
        data_req  = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("timeout_single");
  endtask

  // Both requests raised in the same cycle; 'a' must be served first.
  task automatic run_pair(input vec_t a, input vec_t b, input int lat_b);
    bit ok;
    tick();
    sb.push_back(mk(a, a.lat, cyc));
    sb.push_back(mk(b, lat_b, cyc));
    drive(a);
    drive(b);
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (fetch_done) fetch_req = 1'b0;
      if (data_done)  data_req  = 1'b0;
      if (!fetch_req && !data_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("timeout_pair");
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; cap_n = 0;
    cap_hdr = '0; cap_dat = '0; cs_seen = '0;
    rst_n = 1'b0; spi_miso = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_size = '0; data_addr = '0; data_wdata = '0;

    tbl[0] = mkv(1, 0, 2'd0, 25'h0000010, 32'h0,        32'h00000013, 32'h00000013, 129);
    tbl[1] = mkv(0, 1, 2'd0, 25'h1000020, 32'hAABBCC5A, 32'h0,        32'h0,        81);
    tbl[2] = mkv(0, 0, 2'd1, 25'h1000040, 32'h0,        32'hEEEE1234, 32'h00001234, 97);
    tbl[3] = mkv(0, 1, 2'd2, 25'h0000100, 32'h12345678, 32'h0,        32'h0,        1);
    tbl[4] = mkv(0, 0, 2'd3, 25'h0ABCDEF, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 129);
    tbl[5] = mkv(0, 1, 2'd2, 25'h1FFFFFC, 32'h11223344, 32'h0,        32'h0,        129);
    tbl[6] = mkv(0, 0, 2'd0, 25'h00000FF, 32'h0,        32'h777777A5, 32'h000000A5, 81);
    tbl[7] = mkv(1, 0, 2'd0, 25'h1123456, 32'h0,        32'h87654321, 32'h87654321, 129);

    repeat (3) tick();
    chk("reset_sclk",   64'(spi_sclk),    64'h0);
    chk("reset_mosi",   64'(spi_mosi),    64'h0);
    chk("reset_cs1_n",  64'(spi_cs1_n),   64'h1);
    chk("reset_cs2_n",  64'(spi_cs2_n),   64'h1);
    chk("reset_done",   64'({fetch_done, data_done}), 64'h0);
    chk("reset_rdata",  64'({fetch_rdata, data_rdata}), 64'h0);
    chk("reset_busy",   64'(busy),        64'h0);
    rst_n = 1'b1;
    tick();

    // last_grant resets to DATA: fetch wins, data follows after one idle cycle.
    run_pair(mkv(1, 0, 2'd0, 25'h0000020, 32'h0, 32'h89ABCDEF, 32'h89ABCDEF, 129),
             mkv(0, 0, 2'd0, 25'h1000030, 32'h0, 32'h000000C3, 32'h000000C3, 81),
             129 + 1 + 81);

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Last grant was a fetch, so data wins this time.
    run_pair(mkv(0, 0, 2'd0, 25'h00000AA, 32'h0, 32'h0000005C, 32'h0000005C, 81),
             mkv(1, 0, 2'd0, 25'h0000040, 32'h0, 32'h01020304, 32'h01020304, 129),
             81 + 1 + 129);

    tick();
    fetch_addr = 25'h0000200;
    fetch_req  = 1'b1;
    repeat (40) tick();
    chk("mid_addr_busy",   64'(busy),      64'h1);
    chk("mid_addr_cs1_n",  64'(spi_cs1_n), 64'h0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_cs1_n", 64'(spi_cs1_n), 64'h1);
    chk("async_rst_cs2_n", 64'(spi_cs2_n), 64'h1);
    chk("async_rst_sclk",  64'(spi_sclk),  64'h0);
    chk("async_rst_busy",  64'(busy),      64'h0);
    fetch_req = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    run_vec(mkv(1, 0, 2'd0, 25'h0000200, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 129));
    repeat (4) tick();
    chk("scoreboard_empty", 64'(sb.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_mem_arbiter.md
Name: spi_mem_arbiter

Overview:
- Shares the single SPI bus (sclk/mosi/miso) between the CPU instruction-fetch port and the load/store data port.
- Sequences complete SPI memory transactions: command, 24-bit address, then 1/2/4 data bytes.
- Selects flash (cs1) or external RAM (cs2) from address bit 24.
- Sits between the CPU core and the top-level pins uo_out[5:3], uio_out[0] and ui_in[2].

Parameters:
- ADDR_W, 25, requester address width; bit ADDR_W-1 is the chip select (0 = flash, 1 = RAM).
- CMD_READ, 8'h03, SPI read opcode.
- CMD_WRITE, 8'h02, SPI write opcode.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- fetch_req  in  1  fetch request; level, held until fetch_done
- fetch_addr  in  ADDR_W  fetch byte address
- fetch_done  out  1  one-cycle completion pulse
- fetch_rdata  out  32  fetched word; valid while fetch_done=1
- data_req  in  1  load/store request; level, held until data_done
- data_we  in  1  1 = write, 0 = read
- data_size  in  2  0 = 1 byte, 1 = 2 bytes, 2 or 3 = 4 bytes
- data_addr  in  ADDR_W  data byte address
- data_wdata  in  32  write data; byte0 = bits[7:0]
- data_done  out  1  one-cycle completion pulse
- data_rdata  out  32  read data, zero-extended; valid while data_done=1
- spi_sclk  out  1  SPI clock, mode 0
- spi_mosi  out  1  SPI data out, MSB first
- spi_miso  in  1  SPI data in
- spi_cs1_n  out  1  flash select, active low
- spi_cs2_n  out  1  RAM select, active low
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: spi_sclk=0, spi_mosi=0, spi_cs1_n=1, spi_cs2_n=1, both done signals 0, both rdata outputs 0, busy=0, state IDLE, last_grant=DATA.
- Reset asserted mid-transaction: the chip select deasserts immediately (asynchronous); nothing is delivered to the requester.
- States and transitions:
  - IDLE -> CMD -> ADDR -> DATA -> DONE -> IDLE.
  - IDLE -> DONE directly for a flash write.
- Arbitration (IDLE only):
  - If exactly one request is high, grant it.
  - If both are high, grant the port other than last_grant (round-robin).
  - last_grant updates on every accept.
  - At accept, register addr, we, size and wdata; requester inputs are don't-care afterwards.
  - Fetch is always a 4-byte read.
- Bit timing:
  - Each SPI bit takes 2 clk cycles: a low phase then a high phase.
  - MOSI changes at the start of the low phase.
  - MISO is sampled at the clk edge that ends the high phase.
  - sclk is 0 in IDLE and DONE.
- CMD: 8 bits of CMD_READ or CMD_WRITE. Chip select asserts on the first CMD cycle and stays low through the last DATA bit.
- ADDR: address bits [23:0], MSB first.
- DATA:
  - N = 1, 2 or 4 bytes, byte0 first, MSB first within each byte.
  - Reads shift byte k into rdata[8k+7:8k]; unused upper bytes read as 0.
  - Writes transmit data_wdata bytes 0..N-1.
- DONE:
  - Lasts exactly 1 cycle; chip select high, the granted port's done=1 with rdata valid.
  - The requester drops req on the edge that ends its done cycle.
  - A request still high in the following IDLE cycle is treated as a new request.
- Latency: accept edge to done cycle is 1 + 2*(32+8N) cycles (129 cycles for a 4-byte read).
- Flash write (addr bit 24 = 0, we = 1): no SPI activity, no chip select; done is asserted 1 cycle after accept.
- Back-to-back transactions: at least 1 IDLE cycle with both chip selects high separates them.
- Counters:
  - One bit counter per phase, 5 bits, sized for 32 bits.
  - The counter wraps to 0 on each phase change.

Decomposition:
- Package rv32e_spi_pkg holds:
  - state enum {IDLE, CMD, ADDR, DATA, DONE}
  - size encodings SZ_B / SZ_H / SZ_W
  - requester id enum {REQ_FETCH, REQ_DATA}
  - opcode constants
- One sub-module, spi_shift_engine:
  - 2-phase sclk generator with a 32-bit TX/RX shift register.
  - Load/start/nbits inputs, bit_done/phase_done outputs.
  - The arbiter FSM drives it for each phase.

Test Plan:
- Fetch-only read, fetch_addr=0x000010, MISO model returns 0x13,0x00,0x00,0x00 -> cs1_n low; MOSI carries 0x03,0x00,0x00,0x10; fetch_done exactly 129 cycles after accept; fetch_rdata=0x00000013; cs2_n stays 1.
- RAM byte write, data_addr=0x1000020, data_size=0, data_wdata=0xAABBCC5A -> cs2_n low; MOSI carries 0x02,0x00,0x00,0x20,0x5A; data_done 81 cycles after accept.
- Both requests high in the same cycle with last_grant=DATA -> fetch granted first and data next; a further simultaneous pair is then granted DATA first.
- RAM halfword read, MISO returns 0x34,0x12 -> data_rdata=0x00001234.
- Flash write (addr=0x000100, we=1) -> no sclk toggles, both chip selects stay 1, data_done pulses 1 cycle after accept.
- rst_n pulled low during the ADDR phase -> cs1_n=1 immediately, sclk=0; after release, a new fetch completes normally with correct data.
